// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onchip_mem_arbiter_if : per-master memory bus (ONCHIP_ARB_LOCK_EN adds lock) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
`ifdef ONCHIP_ARB_LOCK_EN
  logic                lock;

  modport master (output address, byteenable, read, write, writedata, lock,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, byteenable, read, write, writedata, lock,
                  output waitrequest, readdata, readdatavalid);
`else
  modport master (output address, byteenable, read, write, writedata,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, byteenable, read, write, writedata,
                  output waitrequest, readdata, readdatavalid);
`endif
endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onchip_mem_arbiter : 2-master round-robin arbiter for a 1-cycle RAM  |
// | Optional bus lock via ONCHIP_ARB_LOCK_EN.  Rev 1.0                   |
// +----------------------------------------------------------------------+
module onchip_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       gnt_valid;
  logic       gnt_idx;
  logic       lock_hold;
  logic       last_grant_q, last_grant_d;
  logic [1:0] rvalid_q, rvalid_d;

  assign req = {m1.read | m1.write, m0.read | m0.write};

`ifdef ONCHIP_ARB_LOCK_EN
  localparam logic [4:0] LOCK_MAX = 5'd16;

  typedef enum logic [0:0] {LOCK_IDLE = 1'b0, LOCK_HELD = 1'b1} lock_state_t;

  lock_state_t lock_state_q, lock_state_d;
  logic [4:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]  lock;

  assign lock = {m1.lock, m0.lock};

  // The previous owner keeps the bus only while it is still inside its lock window.
  assign lock_hold = (lock_state_q == LOCK_HELD) && req[last_grant_q] &&
                     lock[last_grant_q] && (lock_cnt_q < LOCK_MAX);

  always_comb begin
    lock_state_d = lock_state_q;
    lock_cnt_d   = lock_cnt_q;
    if (gnt_valid) begin
      if (lock[gnt_idx]) begin
        lock_state_d = LOCK_HELD;
        if ((lock_state_q == LOCK_HELD) && (gnt_idx == last_grant_q) &&
            (lock_cnt_q < LOCK_MAX))
          lock_cnt_d = lock_cnt_q + 5'd1;
        else
          lock_cnt_d = 5'd1;
      end else begin
        lock_state_d = LOCK_IDLE;
        lock_cnt_d   = 5'd0;
      end
    end else if (!lock[last_grant_q]) begin
      lock_state_d = LOCK_IDLE;
      lock_cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_q <= LOCK_IDLE;
      lock_cnt_q   <= 5'd0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = last_grant_q;
    if (lock_hold)
      gnt_idx = last_grant_q;
    else if (req == 2'b11)
      gnt_idx = ~last_grant_q;
    else
      gnt_idx = req[1];
    grant        = gnt_valid ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    last_grant_d = gnt_valid ? gnt_idx : last_grant_q;
    // A simultaneous read+write is a write and produces no read response.
    rvalid_d[0]  = grant[0] & m0.read & ~m0.write;
    rvalid_d[1]  = grant[1] & m1.read & ~m1.write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rvalid_q     <= 2'b00;
    end else begin
      last_grant_q <= last_grant_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign m0.waitrequest   = req[0] & ~grant[0];
  assign m1.waitrequest   = req[1] & ~grant[1];
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rvalid_q[0];
  assign m1.readdatavalid = rvalid_q[1];

  assign mem_address    = gnt_idx ? m1.address    : m0.address;
  assign mem_byteenable = gnt_idx ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = gnt_idx ? m1.writedata  : m0.writedata;
  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & (gnt_idx ? m1.write : m0.write);
  assign mem_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_onchip_mem_arbiter : directed vector bench with a 1-cycle RAM     |
// | model; lock sequence runs when ONCHIP_ARB_LOCK_EN is defined. Rev 1.0|
// +----------------------------------------------------------------------+
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: each word starts as A5A5_<index>, registered read data.
  logic [31:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[9:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address[9:0]];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [14:0] a0,
                       input logic [3:0] be0, input logic [31:0] wd0,
                       input logic r1, input logic [14:0] a1);
    m0_if.read = r0;  m0_if.write = w0; m0_if.address = a0;
    m0_if.byteenable = be0; m0_if.writedata = wd0;
    m1_if.read = r1;  m1_if.write = 1'b0; m1_if.address = a1;
    m1_if.byteenable = 4'hF; m1_if.writedata = 32'h0;
  endtask

  typedef struct {
    logic r0, w0; logic [14:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic r1;     logic [14:0] a1;
    logic e_wait0, e_wait1, e_cs, e_we; logic [14:0] e_addr;
    logic e_rv0, e_rv1; logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [16];

  initial begin
    //            r0 w0 a0      be0   wd0           r1 a1      wt0 wt1 cs we addr    rv0 rv1 rdata
    vecs[0]  = '{1, 0, 15'h010, 4'hF, 32'h0,        1, 15'h020, 0, 1, 1, 0, 15'h010, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 15'h010, 4'hF, 32'h0,        1, 15'h020, 1, 0, 1, 0, 15'h020, 1, 0, 32'hA5A50010};
    vecs[2]  = '{1, 0, 15'h010, 4'hF, 32'h0,        1, 15'h020, 0, 1, 1, 0, 15'h010, 0, 1, 32'hA5A50020};
    vecs[3]  = '{0, 0, 15'h000, 4'hF, 32'h0,        0, 15'h000, 0, 0, 0, 0, 15'h000, 1, 0, 32'hA5A50010};
    vecs[4]  = '{0, 1, 15'h005, 4'h3, 32'hDEADBEEF, 0, 15'h000, 0, 0, 1, 1, 15'h005, 0, 0, 32'h0};
    vecs[5]  = '{1, 0, 15'h005, 4'hF, 32'h0,        0, 15'h000, 0, 0, 1, 0, 15'h005, 0, 0, 32'h0};
    vecs[6]  = '{0, 0, 15'h000, 4'hF, 32'h0,        0, 15'h000, 0, 0, 0, 0, 15'h000, 1, 0, 32'hA5A5BEEF};
    vecs[7]  = '{1, 1, 15'h007, 4'hF, 32'h11223344, 0, 15'h000, 0, 0, 1, 1, 15'h007, 0, 0, 32'h0};
    vecs[8]  = '{0, 0, 15'h000, 4'hF, 32'h0,        0, 15'h000, 0, 0, 0, 0, 15'h000, 0, 0, 32'h0};
    vecs[9]  = '{0, 0, 15'h000, 4'hF, 32'h0,        1, 15'h007, 0, 0, 1, 0, 15'h007, 0, 0, 32'h0};
    vecs[10] = '{0, 0, 15'h000, 4'hF, 32'h0,        1, 15'h100, 0, 0, 1, 0, 15'h100, 0, 1, 32'h11223344};
    vecs[11] = '{0, 0, 15'h000, 4'hF, 32'h0,        1, 15'h101, 0, 0, 1, 0, 15'h101, 0, 1, 32'hA5A50100};
    vecs[12] = '{0, 0, 15'h000, 4'hF, 32'h0,        1, 15'h102, 0, 0, 1, 0, 15'h102, 0, 1, 32'hA5A50101};
    vecs[13] = '{0, 0, 15'h000, 4'hF, 32'h0,        1, 15'h103, 0, 0, 1, 0, 15'h103, 0, 1, 32'hA5A50102};
    vecs[14] = '{0, 0, 15'h000, 4'hF, 32'h0,        0, 15'h000, 0, 0, 0, 0, 15'h000, 0, 1, 32'hA5A50103};
    vecs[15] = '{0, 0, 15'h000, 4'hF, 32'h0,        0, 15'h000, 0, 0, 0, 0, 15'h000, 0, 0, 32'h0};

    reset = 1'b1;
`ifdef ONCHIP_ARB_LOCK_EN
    m0_if.lock = 1'b0;
    m1_if.lock = 1'b0;
`endif
    drive(0, 0, 15'h0, 4'hF, 32'h0, 0, 15'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rv0", 32'(m0_if.readdatavalid), 32'h0);
    chk("reset rv1", 32'(m1_if.readdatavalid), 32'h0);
    chk("reset clken", 32'(mem_clken), 32'h1);

    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].be0, vecs[i].wd0, vecs[i].r1, vecs[i].a1);
      @(negedge clk);
      chk($sformatf("v%0d wait0", i), 32'(m0_if.waitrequest), 32'(vecs[i].e_wait0));
      chk($sformatf("v%0d wait1", i), 32'(m1_if.waitrequest), 32'(vecs[i].e_wait1));
      chk($sformatf("v%0d cs", i),    32'(mem_chipselect),    32'(vecs[i].e_cs));
      chk($sformatf("v%0d we", i),    32'(mem_write),         32'(vecs[i].e_we));
      if (vecs[i].e_cs)
        chk($sformatf("v%0d addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d be", i), 32'(mem_byteenable), 32'(vecs[i].be0));
        chk($sformatf("v%0d wd", i), mem_writedata, vecs[i].wd0);
      end
      chk($sformatf("v%0d rv0", i), 32'(m0_if.readdatavalid), 32'(vecs[i].e_rv0));
      chk($sformatf("v%0d rv1", i), 32'(m1_if.readdatavalid), 32'(vecs[i].e_rv1));
      if (vecs[i].e_rv0) chk($sformatf("v%0d rdata0", i), m0_if.readdata, vecs[i].e_rdata);
      if (vecs[i].e_rv1) chk($sformatf("v%0d rdata1", i), m1_if.readdata, vecs[i].e_rdata);
    end

    // Reset lands in the grant cycle of an m0 read: response dropped, m0 wins next contest.
    @(posedge clk); #1;
    drive(0, 0, 15'h0, 4'hF, 32'h0, 1, 15'h020);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, 0, 15'h010, 4'hF, 32'h0, 0, 15'h0);
    @(negedge clk);
    chk("rst grant wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("rst grant cs", 32'(mem_chipselect), 32'h1);
    chk("rst grant addr", 32'(mem_address), 32'h010);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 0, 15'h010, 4'hF, 32'h0, 1, 15'h020);
    @(negedge clk);
    chk("rst dropped rv0", 32'(m0_if.readdatavalid), 32'h0);
    chk("rst contest wait0", 32'(m0_if.waitrequest), 32'h0);
    chk("rst contest wait1", 32'(m1_if.waitrequest), 32'h1);
    chk("rst contest addr", 32'(mem_address), 32'h010);
    @(posedge clk); #1;
    drive(0, 0, 15'h0, 4'hF, 32'h0, 0, 15'h0);
    @(negedge clk);
    chk("post rst rv0", 32'(m0_if.readdatavalid), 32'h1);
    chk("post rst rdata0", m0_if.readdata, 32'hA5A50010);

`ifdef ONCHIP_ARB_LOCK_EN
    // m0 locked and contending with m1: 16 grants to m0, then m1 on cycle 17.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m0_if.lock = 1'b1;
    drive(1, 0, 15'h010, 4'hF, 32'h0, 1, 15'h020);
    for (int c = 1; c <= 20; c++) begin
      if (c != 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c <= 16)
        chk($sformatf("lock c%0d wait0", c), 32'(m0_if.waitrequest), 32'h0);
      else if (c == 17)
        chk("lock c17 wait1", 32'(m1_if.waitrequest), 32'h0);
    end
    @(posedge clk); #1;
    m0_if.lock = 1'b0;
    drive(0, 0, 15'h0, 4'hF, 32'h0, 0, 15'h0);
`endif

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
